// File: rtl/err_counter.sv
// Error-event counter: one count per cycle with inc high, optional saturation,
// and a sticky overflow flag set by any increment requested at all-ones.
module err_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] counter,
    output logic             full,
    output logic             overflow
);

    logic [WIDTH-1:0] counter_d, counter_q;
    logic             overflow_d, overflow_q;

    assign full     = &counter_q;
    assign counter  = counter_q;
    assign overflow = overflow_q;

    always_comb begin
        counter_d  = counter_q;
        overflow_d = overflow_q;
        if (inc) begin
            if (full) begin
                // At all-ones: saturate (hold) or wrap to zero; either way flag it.
                overflow_d = 1'b1;
                if (!SATURATE) begin
                    counter_d = '0;
                end
            end else begin
                counter_d = counter_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_err_counter.sv
// Bench for err_counter: three configurations (8-bit saturating, 4-bit
// saturating, 4-bit wrapping) driven in lockstep against an increment-total model.
module tb_err_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inc = 1'b0;

    logic [7:0] c8;
    logic       f8, o8;
    logic [3:0] c4s;
    logic       f4s, o4s;
    logic [3:0] c4w;
    logic       f4w, o4w;

    int unsigned nchk  = 0;
    int unsigned npass = 0;
    longint      tot   = 0;   // increments accepted since last reset
    int          cyc   = 0;

    always #5 clk = ~clk;

    err_counter #(.WIDTH(8), .SATURATE(1'b1)) u_d8 (
        .clk(clk), .rst(rst), .inc(inc), .counter(c8), .full(f8), .overflow(o8));
    err_counter #(.WIDTH(4), .SATURATE(1'b1)) u_s4 (
        .clk(clk), .rst(rst), .inc(inc), .counter(c4s), .full(f4s), .overflow(o4s));
    err_counter #(.WIDTH(4), .SATURATE(1'b0)) u_w4 (
        .clk(clk), .rst(rst), .inc(inc), .counter(c4w), .full(f4w), .overflow(o4w));

    logic [21:0] obs;
    assign obs = {c8, f8, o8, c4s, f4s, o4s, c4w, f4w, o4w};

    function automatic logic [21:0] exp_vec();
        longint e8, e4s, e4w;
        e8  = (tot > 255) ? 255 : tot;
        e4s = (tot > 15) ? 15 : tot;
        e4w = tot % 16;
        return {e8[7:0], e8 == 255, tot > 255,
                e4s[3:0], e4s == 15, tot > 15,
                e4w[3:0], e4w == 15, tot > 15};
    endfunction

    // Drive one cycle, advance the model, and land #1 after the edge.
    task automatic step(input logic r, input logic i);
        rst = r;
        inc = i;
        @(posedge clk);
        if (r) tot = 0;
        else if (i) tot++;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        nchk++;
        if (obs !== exp_vec() || obs !== 22'd0)
            $display("FAIL reset_hold cyc %0d: got %h want %h", cyc, obs, exp_vec());
        else npass++;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        nchk++;
        if (c8 !== 8'd5) $display("FAIL preload5: got %0d want 5", c8);
        else npass++;
        step(1'b1, 1'b0);
        nchk++;
        if (obs !== exp_vec() || c8 !== 8'd0 || o8 !== 1'b0 || f8 !== 1'b0)
            $display("FAIL reset_clear: got %h want %h", obs, exp_vec());
        else npass++;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            step(1'b0, i <= 10);
            nchk++;
            if (obs !== exp_vec() || c8 !== 8'((i <= 10) ? i : 10))
                $display("FAIL basic step %0d: got %h want %h", i, obs, exp_vec());
            else npass++;
        end
    endtask

    task automatic test_rst_inc();
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        nchk++;
        if (c8 !== 8'd7) $display("FAIL preload7: got %0d want 7", c8);
        else npass++;
        step(1'b1, 1'b1);
        nchk++;
        if (obs !== exp_vec() || c8 !== 8'd0)
            $display("FAIL rst_with_inc: got %h want %h", obs, exp_vec());
        else npass++;
        step(1'b0, 1'b1);
        nchk++;
        if (obs !== exp_vec() || c8 !== 8'd1)
            $display("FAIL resume_after_rst: got %h want %h", obs, exp_vec());
        else npass++;
    endtask

    task automatic test_saturate_wrap();
        step(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1);
            nchk++;
            if (obs !== exp_vec())
                $display("FAIL sat_wrap inc %0d: got %h want %h", i, obs, exp_vec());
            else npass++;
            if (i == 15) begin
                nchk++;
                if (c4s !== 4'd15 || f4s !== 1'b1 || o4s !== 1'b0 || c4w !== 4'd15)
                    $display("FAIL at15: got s=%0d f=%b o=%b w=%0d want 15 1 0 15", c4s, f4s, o4s, c4w);
                else npass++;
            end
            if (i == 16) begin
                nchk++;
                if (c4s !== 4'd15 || o4s !== 1'b1 || c4w !== 4'd0 || o4w !== 1'b1 || f4w !== 1'b0)
                    $display("FAIL at16: got s=%0d os=%b w=%0d ow=%b want 15 1 0 1", c4s, o4s, c4w, o4w);
                else npass++;
            end
            if (i == 17) begin
                nchk++;
                if (c4w !== 4'd1 || o4w !== 1'b1)
                    $display("FAIL at17: got w=%0d ow=%b want 1 1", c4w, o4w);
                else npass++;
            end
        end
        step(1'b0, 1'b0);
        nchk++;
        if (obs !== exp_vec() || o4s !== 1'b1)
            $display("FAIL sticky_hold: got %h want %h", obs, exp_vec());
        else npass++;
        step(1'b1, 1'b0);
        nchk++;
        if (obs !== 22'd0)
            $display("FAIL sat_wrap_rst: got %h want 0", obs);
        else npass++;
    endtask

    task automatic test_sparse();
        step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, (i % 2) == 0);
        nchk++;
        if (obs !== exp_vec() || c8 !== 8'd20 || o8 !== 1'b0)
            $display("FAIL sparse: got c8=%0d o8=%b want 20 0", c8, o8);
        else npass++;
    endtask

    task automatic test_random();
        step(1'b1, 1'b0);
        // Long reset-free run drives the 8-bit counter through saturation.
        for (int i = 0; i < 600; i++) begin
            step(1'b0, $urandom_range(0, 3) != 0);
            nchk++;
            if (obs !== exp_vec())
                $display("FAIL rand_long cyc %0d: got %h want %h", cyc, obs, exp_vec());
            else npass++;
        end
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 30) == 0, $urandom_range(0, 1) != 0);
            nchk++;
            if (obs !== exp_vec())
                $display("FAIL rand_rst cyc %0d: got %h want %h", cyc, obs, exp_vec());
            else npass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rst_inc();
        test_saturate_wrap();
        test_sparse();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
